// File: rtl/afu_mem_responder.sv
// AFU cache-line memory responder: queued read/write requests serviced against a
// line-wide internal memory. AFU_MEM_RESP_ERR_CHECK_EN enables the sticky error flags.
module afu_mem_req_fifo #(
  parameter int W  = 8,
  parameter int DB = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  output logic         pop_o,
  output logic [W-1:0] dout_o,
  output logic         almostfull_o,
  output logic         ovf_o
);
  localparam int DEPTH = 2**DB;

  logic [W-1:0]  mem_q [DEPTH];
  logic [DB-1:0] rptr_q, wptr_q;
  logic [DB:0]   cnt_q, cnt_d;
  logic          af_q, full, push;

  // The head is drained every cycle the queue holds anything.
  assign pop_o        = (cnt_q != '0);
  assign full         = (cnt_q == (DB+1)'(DEPTH));
  assign push         = push_i && (!full || pop_o);
  assign ovf_o        = push_i && full && !pop_o;
  assign dout_o       = mem_q[rptr_q];
  assign almostfull_o = af_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop_o)      cnt_d = cnt_q + (DB+1)'(1);
    else if (!push && pop_o) cnt_d = cnt_q - (DB+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      af_q   <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= wptr_q + DB'(1);
      end
      if (pop_o) rptr_q <= rptr_q + DB'(1);
      cnt_q <= cnt_d;
      af_q  <= (int'(cnt_d) >= DEPTH - 4);
    end
  end
endmodule

module afu_mem_responder #(
  parameter int ADDR_LMT        = 58,
  parameter int MDATA           = 14,
  parameter int CACHE_WIDTH     = 512,
  parameter int MEM_DEPTH_BITS  = 10,
  parameter int FIFO_DEPTH_BITS = 3,
  parameter int RD_LATENCY      = 4,
  parameter int WR_LATENCY      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_LMT-1:0]    rd_req_addr,
  input  logic [MDATA-1:0]       rd_req_mdata,
  input  logic                   rd_req_en,
  output logic                   rd_req_almostfull,
  output logic                   rd_rsp_valid,
  output logic [MDATA-1:0]       rd_rsp_mdata,
  output logic [CACHE_WIDTH-1:0] rd_rsp_data,
  input  logic [ADDR_LMT-1:0]    wr_req_addr,
  input  logic [MDATA-1:0]       wr_req_mdata,
  input  logic [CACHE_WIDTH-1:0] wr_req_data,
  input  logic                   wr_req_en,
  output logic                   wr_req_almostfull,
  output logic                   wr_rsp0_valid,
  output logic [MDATA-1:0]       wr_rsp0_mdata,
  output logic                   wr_rsp1_valid,
  output logic [MDATA-1:0]       wr_rsp1_mdata,
  output logic                   err_overflow,
  output logic                   err_addr_range
);
  localparam int LINES = 2**MEM_DEPTH_BITS;

  typedef struct packed {
    logic [MEM_DEPTH_BITS-1:0] idx;
    logic [MDATA-1:0]          mdata;
  } rd_req_t;

  typedef struct packed {
    logic [MEM_DEPTH_BITS-1:0] idx;
    logic [MDATA-1:0]          mdata;
    logic [CACHE_WIDTH-1:0]    data;
  } wr_req_t;

  rd_req_t rd_in, rd_head;
  wr_req_t wr_in, wr_head;
  logic    rd_pop, wr_pop, rd_ovf, wr_ovf;

  // Only the wrapped index is queued; the upper address bits feed the range check alone.
  assign rd_in = {rd_req_addr[MEM_DEPTH_BITS-1:0], rd_req_mdata};
  assign wr_in = {wr_req_addr[MEM_DEPTH_BITS-1:0], wr_req_mdata, wr_req_data};

  afu_mem_req_fifo #(.W($bits(rd_req_t)), .DB(FIFO_DEPTH_BITS)) u_rd_fifo (
    .clk(clk), .reset(reset), .push_i(rd_req_en), .din_i(rd_in), .pop_o(rd_pop),
    .dout_o(rd_head), .almostfull_o(rd_req_almostfull), .ovf_o(rd_ovf));

  afu_mem_req_fifo #(.W($bits(wr_req_t)), .DB(FIFO_DEPTH_BITS)) u_wr_fifo (
    .clk(clk), .reset(reset), .push_i(wr_req_en), .din_i(wr_in), .pop_o(wr_pop),
    .dout_o(wr_head), .almostfull_o(wr_req_almostfull), .ovf_o(wr_ovf));

  logic [CACHE_WIDTH-1:0] mem_q [LINES];
  logic [RD_LATENCY-1:0]  rd_vld_q;
  logic [MDATA-1:0]       rd_md_q  [RD_LATENCY];
  logic [CACHE_WIDTH-1:0] rd_dat_q [RD_LATENCY];

  // Read-first memory: the read of a popped request samples mem_q before this edge's write.
  // Later stages load only behind a valid so the outputs hold their last response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        rd_md_q[i]  <= '0;
        rd_dat_q[i] <= '0;
      end
    end else begin
      rd_vld_q <= (rd_vld_q << 1) | RD_LATENCY'(rd_pop);
      if (rd_pop) begin
        rd_md_q[0]  <= rd_head.mdata;
        rd_dat_q[0] <= mem_q[rd_head.idx];
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        if (rd_vld_q[i-1]) begin
          rd_md_q[i]  <= rd_md_q[i-1];
          rd_dat_q[i] <= rd_dat_q[i-1];
        end
      end
      if (wr_pop) mem_q[wr_head.idx] <= wr_head.data;
    end
  end

  assign rd_rsp_valid = rd_vld_q[RD_LATENCY-1];
  assign rd_rsp_mdata = rd_md_q[RD_LATENCY-1];
  assign rd_rsp_data  = rd_dat_q[RD_LATENCY-1];

  logic [WR_LATENCY-1:0] wr_vld_q, wr_ch_q;
  logic [MDATA-1:0]      wr_md0_q [WR_LATENCY];
  logic [MDATA-1:0]      wr_md1_q [WR_LATENCY];
  logic                  wr_tog_q;

  // Completions leave strictly in pop order, so the channel can be bound at pop time.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_vld_q <= '0;
      wr_ch_q  <= '0;
      wr_tog_q <= 1'b0;
      for (int i = 0; i < WR_LATENCY; i++) begin
        wr_md0_q[i] <= '0;
        wr_md1_q[i] <= '0;
      end
    end else begin
      wr_vld_q <= (wr_vld_q << 1) | WR_LATENCY'(wr_pop);
      wr_ch_q  <= (wr_ch_q << 1) | WR_LATENCY'(wr_tog_q);
      if (wr_pop) begin
        wr_tog_q <= ~wr_tog_q;
        if (wr_tog_q) wr_md1_q[0] <= wr_head.mdata;
        else          wr_md0_q[0] <= wr_head.mdata;
      end
      for (int i = 1; i < WR_LATENCY; i++) begin
        if (wr_vld_q[i-1]) begin
          if (wr_ch_q[i-1]) wr_md1_q[i] <= wr_md1_q[i-1];
          else              wr_md0_q[i] <= wr_md0_q[i-1];
        end
      end
    end
  end

  assign wr_rsp0_valid = wr_vld_q[WR_LATENCY-1] & ~wr_ch_q[WR_LATENCY-1];
  assign wr_rsp1_valid = wr_vld_q[WR_LATENCY-1] &  wr_ch_q[WR_LATENCY-1];
  assign wr_rsp0_mdata = wr_md0_q[WR_LATENCY-1];
  assign wr_rsp1_mdata = wr_md1_q[WR_LATENCY-1];

`ifdef AFU_MEM_RESP_ERR_CHECK_EN
  logic ovf_q, arng_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      arng_q <= 1'b0;
    end else begin
      if (rd_ovf || wr_ovf) ovf_q <= 1'b1;
      if ((rd_req_en && |rd_req_addr[ADDR_LMT-1:MEM_DEPTH_BITS]) ||
          (wr_req_en && |wr_req_addr[ADDR_LMT-1:MEM_DEPTH_BITS])) arng_q <= 1'b1;
    end
  end

  assign err_overflow   = ovf_q;
  assign err_addr_range = arng_q;
`else
  logic unused;
  assign unused = ^{rd_ovf, wr_ovf, rd_req_addr[ADDR_LMT-1:MEM_DEPTH_BITS],
                    wr_req_addr[ADDR_LMT-1:MEM_DEPTH_BITS]};
  assign err_overflow   = 1'b0;
  assign err_addr_range = 1'b0;
`endif
endmodule

// File: tb/tb_afu_mem_responder.sv
// Self-checking bench for afu_mem_responder: directed table, hazard/ordering/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_afu_mem_responder;
  localparam int AL = 58, MD = 14, CW = 512, MDB = 10, FDB = 3, RL = 4, WL = 2;
  localparam int DEPTH = 2**FDB;
`ifdef AFU_MEM_RESP_ERR_CHECK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1;
  logic [AL-1:0] rd_req_addr = '0, wr_req_addr = '0;
  logic [MD-1:0] rd_req_mdata = '0, wr_req_mdata = '0;
  logic [CW-1:0] wr_req_data = '0;
  logic rd_req_en = 1'b0, wr_req_en = 1'b0;
  logic rd_req_almostfull, rd_rsp_valid, wr_req_almostfull, wr_rsp0_valid, wr_rsp1_valid;
  logic err_overflow, err_addr_range;
  logic [MD-1:0] rd_rsp_mdata, wr_rsp0_mdata, wr_rsp1_mdata;
  logic [CW-1:0] rd_rsp_data;

  always #5 clk = ~clk;

  afu_mem_responder #(.ADDR_LMT(AL), .MDATA(MD), .CACHE_WIDTH(CW), .MEM_DEPTH_BITS(MDB),
    .FIFO_DEPTH_BITS(FDB), .RD_LATENCY(RL), .WR_LATENCY(WL)) dut (
    .clk(clk), .reset(reset),
    .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
    .rd_req_almostfull(rd_req_almostfull), .rd_rsp_valid(rd_rsp_valid),
    .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
    .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
    .wr_req_en(wr_req_en), .wr_req_almostfull(wr_req_almostfull),
    .wr_rsp0_valid(wr_rsp0_valid), .wr_rsp0_mdata(wr_rsp0_mdata),
    .wr_rsp1_valid(wr_rsp1_valid), .wr_rsp1_mdata(wr_rsp1_mdata),
    .err_overflow(err_overflow), .err_addr_range(err_addr_range));

  int checks = 0, errors = 0, t = 0;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, t);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: no response within cycle budget (cycle %0d)", nm, t);
  endtask

  // Reference model: request queues, scheduled responses, flat memory image.
  typedef struct { logic [MD-1:0] md; int idx; logic [CW-1:0] d; } req_t;
  typedef struct { int due; logic [MD-1:0] md; logic [CW-1:0] d; bit known; } rsp_t;
  req_t rq[$], wq[$];
  rsp_t rp[$], wp[$];
  logic [CW-1:0] mmem [2**MDB];
  bit mknown [2**MDB];
  bit tog, mvalid;
  logic e_rv, e_w0v, e_w1v, e_raf, e_waf, e_ovf, e_aerr;
  logic [MD-1:0] e_rmd, e_w0md, e_w1md;
  logic [CW-1:0] e_rdata;
  bit e_rknown;

  task automatic model_step();
    if (reset) begin
      rq.delete(); wq.delete(); rp.delete(); wp.delete();
      tog = 0; mvalid = 1; e_rknown = 1;
      {e_rv, e_w0v, e_w1v, e_raf, e_waf, e_ovf, e_aerr} = '0;
      e_rmd = '0; e_w0md = '0; e_w1md = '0; e_rdata = '0;
      return;
    end
    if (rq.size() > 0) begin
      req_t r = rq.pop_front();
      rp.push_back('{t + RL, r.md, mmem[r.idx], mknown[r.idx]});
    end
    if (wq.size() > 0) begin
      req_t w = wq.pop_front();
      wp.push_back('{t + WL, w.md, '0, 1'b1});
      mmem[w.idx] = w.d;
      mknown[w.idx] = 1;
    end
    if (rd_req_en) begin
      if (rq.size() < DEPTH) rq.push_back('{rd_req_mdata, int'(rd_req_addr % (2**MDB)), '0});
      else e_ovf = ERRCHK;
      if (rd_req_addr >= AL'(2**MDB)) e_aerr = ERRCHK;
    end
    if (wr_req_en) begin
      if (wq.size() < DEPTH) wq.push_back('{wr_req_mdata, int'(wr_req_addr % (2**MDB)), wr_req_data});
      else e_ovf = ERRCHK;
      if (wr_req_addr >= AL'(2**MDB)) e_aerr = ERRCHK;
    end
    e_raf = (rq.size() >= DEPTH - 4);
    e_waf = (wq.size() >= DEPTH - 4);
    e_rv = 0;
    if (rp.size() > 0 && rp[0].due == t + 1) begin
      rsp_t x = rp.pop_front();
      e_rv = 1; e_rmd = x.md; e_rdata = x.d; e_rknown = x.known;
    end
    e_w0v = 0; e_w1v = 0;
    if (wp.size() > 0 && wp[0].due == t + 1) begin
      rsp_t x = wp.pop_front();
      if (tog) begin e_w1v = 1; e_w1md = x.md; end
      else     begin e_w0v = 1; e_w0md = x.md; end
      tog = !tog;
    end
  endtask

  // Compare this cycle's outputs, advance the model with this cycle's inputs, step the clock.
  task automatic cycle();
    if (mvalid) begin
      chk("rd_rsp_valid", rd_rsp_valid, e_rv);
      chk("rd_rsp_mdata", rd_rsp_mdata, e_rmd);
      if (e_rknown) chk("rd_rsp_data", rd_rsp_data, e_rdata);
      chk("wr_rsp0_valid", wr_rsp0_valid, e_w0v);
      chk("wr_rsp0_mdata", wr_rsp0_mdata, e_w0md);
      chk("wr_rsp1_valid", wr_rsp1_valid, e_w1v);
      chk("wr_rsp1_mdata", wr_rsp1_mdata, e_w1md);
      chk("rd_req_almostfull", rd_req_almostfull, e_raf);
      chk("wr_req_almostfull", wr_req_almostfull, e_waf);
      chk("err_overflow", err_overflow, e_ovf);
      chk("err_addr_range", err_addr_range, e_aerr);
    end
    model_step();
    @(posedge clk);
    #1;
    t++;
    rd_req_en = 1'b0;
    wr_req_en = 1'b0;
  endtask

  task automatic wait_rd(input string nm, input logic [MD-1:0] md, input logic [CW-1:0] d, input int t0);
    int n = 0;
    while (!rd_rsp_valid && n < 20) begin cycle(); n++; end
    if (!rd_rsp_valid) tmo(nm);
    else begin
      chk({nm, "_lat"}, CW'(t - t0), CW'(1 + RL));
      chk({nm, "_md"}, rd_rsp_mdata, md);
      chk({nm, "_data"}, rd_rsp_data, d);
    end
  endtask

  task automatic wait_wr(input string nm, input logic [MD-1:0] md, input bit ch, input int t0);
    int n = 0;
    while (!(wr_rsp0_valid || wr_rsp1_valid) && n < 20) begin cycle(); n++; end
    if (!(wr_rsp0_valid || wr_rsp1_valid)) tmo(nm);
    else begin
      chk({nm, "_lat"}, CW'(t - t0), CW'(1 + WL));
      chk({nm, "_ch"}, wr_rsp1_valid, ch);
      chk({nm, "_md"}, ch ? wr_rsp1_mdata : wr_rsp0_mdata, md);
    end
  endtask

  function automatic logic [CW-1:0] rand_line();
    logic [CW-1:0] v;
    for (int i = 0; i < CW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  typedef struct {
    bit wr; logic [AL-1:0] addr; logic [MD-1:0] md; logic [CW-1:0] d;
    logic [CW-1:0] exp_d; bit exp_ch; bit exp_aerr;
  } vec_t;
  vec_t vt[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1, 58'h5,   14'h11, {64{8'hA5}},         '0,                  0, 0};
    vt[1] = '{0, 58'h5,   14'h22, '0,                  {64{8'hA5}},         0, 0};
    vt[2] = '{1, 58'h7,   14'h01, '0,                  '0,                  1, 0};
    vt[3] = '{0, 58'h405, 14'h33, '0,                  {64{8'hA5}},         0, ERRCHK};
    vt[4] = '{1, 58'h3FF, 14'h44, {16{32'hDEADBEEF}},  '0,                  0, ERRCHK};
    vt[5] = '{0, 58'h3FF, 14'h45, '0,                  {16{32'hDEADBEEF}},  0, ERRCHK};

    @(posedge clk); #1;
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) cycle();

    // Directed table: one transaction at a time, latency/tag/data/channel checked.
    for (int i = 0; i < 6; i++) begin
      int t0;
      if (vt[i].wr) begin
        wr_req_en = 1; wr_req_addr = vt[i].addr; wr_req_mdata = vt[i].md; wr_req_data = vt[i].d;
      end else begin
        rd_req_en = 1; rd_req_addr = vt[i].addr; rd_req_mdata = vt[i].md;
      end
      t0 = t;
      cycle();
      if (vt[i].wr) wait_wr($sformatf("vec%0d", i), vt[i].md, vt[i].exp_ch, t0);
      else          wait_rd($sformatf("vec%0d", i), vt[i].md, vt[i].exp_d, t0);
      chk($sformatf("vec%0d_aerr", i), err_addr_range, vt[i].exp_aerr);
      cycle();
    end

    // Same-cycle write/read to line 7: read sees the old zero, the next read the ones.
    begin
      int t0;
      wr_req_en = 1; wr_req_addr = 58'h7; wr_req_mdata = 14'h56; wr_req_data = '1;
      rd_req_en = 1; rd_req_addr = 58'h7; rd_req_mdata = 14'h55;
      t0 = t; cycle();
      wait_rd("haz_old", 14'h55, '0, t0);
      cycle();
      rd_req_en = 1; rd_req_addr = 58'h7; rd_req_mdata = 14'h57;
      t0 = t; cycle();
      wait_rd("haz_new", 14'h57, '1, t0);
      cycle();
    end

    // Back-to-back writes from a fresh toggle: channels 0,1,0,1 on consecutive cycles.
    begin
      int got_md[$], got_ch[$], got_t[$];
      reset = 1; cycle(); reset = 0;
      for (int i = 0; i < 14; i++) begin
        if (i < 4) begin
          wr_req_en = 1; wr_req_addr = AL'(8'h10 + i); wr_req_mdata = MD'(i + 1); wr_req_data = rand_line();
        end
        cycle();
        chk("b2b_excl", wr_rsp0_valid & wr_rsp1_valid, 1'b0);
        if (wr_rsp0_valid) begin got_md.push_back(wr_rsp0_mdata); got_ch.push_back(0); got_t.push_back(t); end
        if (wr_rsp1_valid) begin got_md.push_back(wr_rsp1_mdata); got_ch.push_back(1); got_t.push_back(t); end
      end
      chk("b2b_count", CW'(got_md.size()), CW'(4));
      for (int i = 0; i < got_md.size() && i < 4; i++) begin
        chk($sformatf("b2b%0d_md", i), CW'(got_md[i]), CW'(i + 1));
        chk($sformatf("b2b%0d_ch", i), CW'(got_ch[i]), CW'(i % 2));
        if (i > 0) chk($sformatf("b2b%0d_gap", i), CW'(got_t[i] - got_t[i-1]), CW'(1));
      end
    end

    // Ten consecutive reads: concurrent pops keep the queue at one entry.
    begin
      int got[$];
      for (int i = 0; i < 20; i++) begin
        if (i < 10) begin rd_req_en = 1; rd_req_addr = AL'(i); rd_req_mdata = MD'(14'h100 + i); end
        cycle();
        chk("stream_af", rd_req_almostfull, 1'b0);
        if (rd_rsp_valid) got.push_back(rd_rsp_mdata);
      end
      chk("stream_count", CW'(got.size()), CW'(10));
      for (int i = 0; i < got.size() && i < 10; i++)
        chk($sformatf("stream%0d_md", i), CW'(got[i]), CW'(14'h100 + i));
      chk("stream_ovf", err_overflow, 1'b0);
    end

    // Reset with three reads in flight, one out of range: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) begin
      rd_req_en = 1; rd_req_addr = (i == 0) ? 58'h405 : AL'(i); rd_req_mdata = MD'(14'h200 + i);
      cycle();
    end
    reset = 1; cycle(); reset = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("rst_no_rsp", rd_rsp_valid, 1'b0);
      chk("rst_aerr", err_addr_range, 1'b0);
    end

    // Randomized traffic on a small address window with occasional out-of-range and resets.
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      rd_req_en = 1'($urandom_range(0, 1));
      rd_req_addr = ($urandom_range(0, 9) == 0) ? AL'({$urandom, $urandom}) : AL'($urandom_range(0, 15));
      rd_req_mdata = MD'($urandom);
      wr_req_en = 1'($urandom_range(0, 1));
      wr_req_addr = ($urandom_range(0, 9) == 0) ? AL'({$urandom, $urandom}) : AL'($urandom_range(0, 15));
      wr_req_mdata = MD'($urandom);
      wr_req_data = rand_line();
      cycle();
    end
    reset = 0;
    for (int i = 0; i < 12; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
